p2p_link_rx: RTL and testbench

// - Receiving endpoint of the 4-bit point-to-point message link between two nodes.
// - Accepts messages from the remote transmitter over a 4-phase req/ack handshake.
// - Buffers them in a small FIFO and presents them to the local node on a valid/ready interface.
// - Keeps a wrapping count of accepted messages.

---
 rtl/p2p_link_rx.sv | 143 ++++++++++++++
 tb/tb_p2p_link_rx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p2p_link_rx.sv
// Receive side of the 4-bit req/ack message link: sync, FSM, FIFO, counters.
// Optional parity check enabled by defining P2P_PARITY_EN.
module p2p_link_rx #(
  parameter int MSG_W = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             link_req,
  input  logic [MSG_W-1:0] link_data,
  input  logic             link_par,
  output logic             link_ack,
  output logic [MSG_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] msg_count,
  output logic [CNT_W-1:0] par_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    WAIT0 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             req_m_q, req_m_d;
  logic             req_s_q, req_s_d;
  logic             ack_q, ack_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [MSG_W-1:0] mem_q [DEPTH];
  logic [MSG_W-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] perr_q, perr_d;

  logic full;
  logic empty;
  logic wr_en;
  logic rd_en;
  logic perr_inc;
  logic par_ok;

`ifdef P2P_PARITY_EN
  assign par_ok = ((^link_data) == link_par);
`else
  logic unused_par;
  assign par_ok     = 1'b1;
  assign unused_par = link_par;
`endif

  // Same low bits with differing wrap bit means the writer lapped the reader.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign rd_en = out_ready && !empty;

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    cnt_d    = cnt_q;
    perr_d   = perr_q;
    mem_d    = mem_q;
    wr_en    = 1'b0;
    perr_inc = 1'b0;
    req_m_d  = link_req;
    req_s_d  = req_m_q;

    unique case (1'b1)
      (state_q == IDLE): begin
        if (req_s_q && !full) begin
          state_d = ACK;
          ack_d   = 1'b1;
          if (par_ok) begin
            wr_en = 1'b1;
          end else begin
            perr_inc = 1'b1;
          end
        end
      end
      (state_q == ACK): begin
        if (!req_s_q) begin
          state_d = WAIT0;
          ack_d   = 1'b0;
        end
      end
      (state_q == WAIT0): begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase

    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = link_data;
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (perr_inc) begin
      perr_d = perr_q + CNT_W'(1);
    end

    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_m_q  <= 1'b0;
      req_s_q  <= 1'b0;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
      cnt_q    <= '0;
      perr_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_m_q  <= req_m_d;
      req_s_q  <= req_s_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
      cnt_q    <= cnt_d;
      perr_q   <= perr_d;
    end
  end

  assign link_ack  = ack_q;
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign msg_count = cnt_q;
  assign par_err   = perr_q;

endmodule

// File: tb/tb_p2p_link_rx.sv
// Bench for p2p_link_rx: handshake-level scoreboard plus directed scenarios.
// Honours P2P_PARITY_EN the same way as the design.
module tb_p2p_link_rx;

  localparam int DEPTH = 4;
`ifdef P2P_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       link_req;
  logic [3:0] link_data;
  logic       link_par;
  logic       link_ack;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] msg_count;
  logic [7:0] par_err;

  p2p_link_rx dut (
    .clk       (clk),
    .rst       (rst),
    .link_req  (link_req),
    .link_data (link_data),
    .link_par  (link_par),
    .link_ack  (link_ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .msg_count (msg_count),
    .par_err   (par_err)
  );

  int checks = 0;
  int failures = 0;

  logic [3:0] tx_data = '0;
  logic       tx_par = 1'b0;
  logic [3:0] exp_q[$];
  logic [3:0] pop_log[$];
  logic [7:0] exp_cnt = '0;
  logic [7:0] exp_perr = '0;
  logic       prev_ack = 1'b0;
  logic       rst_e = 1'b1;
  logic       rand_rdy = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) rst_e <= rst;

  // Scoreboard: one accepted handshake per ack rise; pops on valid&ready.
  always @(negedge clk) begin
    if (rst_e) begin
      exp_q.delete();
      exp_cnt  = '0;
      exp_perr = '0;
      chk("rst_ack", link_ack, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_count", msg_count, 0);
      chk("rst_perr", par_err, 0);
      chk("rst_data", out_data, 0);
    end else begin
      if (link_ack && !prev_ack) begin
        if (!PAR_EN || ((^tx_data) == tx_par)) begin
          exp_q.push_back(tx_data);
          exp_cnt++;
        end else begin
          exp_perr++;
        end
        chk("fifo_bound", exp_q.size() <= DEPTH, 1);
      end
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && exp_q.size() != 0)
        chk("out_data", out_data, exp_q[0]);
      chk("msg_count", msg_count, exp_cnt);
      chk("par_err", par_err, exp_perr);
      if (out_valid && out_ready && exp_q.size() != 0)
        pop_log.push_back(exp_q.pop_front());
    end
    prev_ack = link_ack;
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_noack();
    int n = 0;
    while (link_ack !== 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_fall", link_ack, 0);
  endtask

  task automatic wait_ack(input int bound, output int lat);
    lat = 0;
    while (link_ack !== 1'b1 && lat < bound) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ack_rise", link_ack, 1);
  endtask

  task automatic start_req(input logic [3:0] d, input logic p);
    wait_noack();
    link_data = d;
    link_par  = p;
    tx_data   = d;
    tx_par    = p;
    link_req  = 1'b1;
  endtask

  task automatic send_msg(input logic [3:0] d, input logic p);
    int lat;
    start_req(d, p);
    wait_ack(400, lat);
    link_data = 4'($urandom);
    link_par  = 1'($urandom);
    link_req  = 1'b0;
    wait_noack();
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", out_valid, 0);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    link_req = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    logic [3:0] d;
    logic bad;
    rst = 1'b1;
    link_req = 1'b0;
    link_data = '0;
    link_par = 1'b0;
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;

    // Single message: latency and delivery.
    start_req(4'b1011, 1'b1);
    wait_ack(20, lat);
    chk("first_latency", lat, 3);
    chk("first_valid", out_valid, 1);
    chk("first_data", out_data, 4'b1011);
    chk("first_count", msg_count, 1);
    link_req = 1'b0;
    wait_noack();
    drain();

    // Fill, backpressure the 5th, pop one, then drain in order.
    pop_log.delete();
    for (int v = 1; v <= 4; v++) begin
      d = 4'(v);
      send_msg(d, ^d);
    end
    start_req(4'd5, 1'b0);
    repeat (12) begin
      @(posedge clk); #1;
    end
    chk("full_no_ack", link_ack, 0);
    chk("full_head", out_data, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_ack(20, lat);
    link_req = 1'b0;
    wait_noack();
    drain();
    chk("drain_len", pop_log.size(), 5);
    for (int i = 0; i < 5 && i < pop_log.size(); i++)
      chk("drain_order", pop_log[i], i + 1);

    // 300 back-to-back messages with the consumer always ready.
    do_reset();
    out_ready = 1'b1;
    repeat (300) begin
      d = 4'($urandom);
      send_msg(d, ^d);
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("count_wrap", msg_count, 44);
    chk("wrap_empty", out_valid, 0);

    // Random gaps, random readiness, occasional bad parity.
    rand_rdy = 1'b1;
    repeat (150) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      d   = 4'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send_msg(d, (^d) ^ bad);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    drain();

    // Reset while acking with two entries queued; held req is a new message.
    do_reset();
    send_msg(4'd3, 1'b0);
    start_req(4'd9, 1'b0);
    wait_ack(20, lat);
    chk("pre_rst_count", msg_count, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ack", link_ack, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", msg_count, 0);
    rst = 1'b0;
    wait_ack(20, lat);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_count", msg_count, 1);
    chk("post_rst_data", out_data, 9);
    link_req = 1'b0;
    wait_noack();
    drain();

    // Parity behaviour on 4'b0111.
    do_reset();
    send_msg(4'b0111, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
`ifdef P2P_PARITY_EN
    chk("bad_par_valid", out_valid, 0);
    chk("bad_par_err", par_err, 1);
    chk("bad_par_count", msg_count, 0);
    send_msg(4'b0111, 1'b1);
    chk("good_par_valid", out_valid, 1);
    chk("good_par_data", out_data, 4'b0111);
    chk("good_par_count", msg_count, 1);
`else
    chk("nopar_valid", out_valid, 1);
    chk("nopar_data", out_data, 4'b0111);
    chk("nopar_err", par_err, 0);
    chk("nopar_count", msg_count, 1);
`endif
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
